// File: rtl/clock_meter_pkg.sv
// Shared definitions for the clock period meter: FSM encoding and counter limits.
package clock_meter_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArm     = 2'd1,
        StMeasure = 2'd2
    } meter_state_e;

    localparam int unsigned MinSyncStages = 2;

    // All-ones value of a width-bit counter, i.e. 2^width - 1.
    function automatic logic [63:0] cnt_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge detector.
module sync_edge_detect
    import clock_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    // Never fewer than two flops, whatever the caller asks for.
    localparam int unsigned Stages = (SYNC_STAGES < MinSyncStages) ? MinSyncStages : SYNC_STAGES;

    logic [Stages-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d};
            prev_q <= sync_q[Stages-1];
        end
    end

    assign q    = sync_q[Stages-1];
    assign rise = sync_q[Stages-1] & ~prev_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of an asynchronous signal in clk cycles, with
// sticky timeout when no rising edge arrives before the period counter saturates.
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sig_in,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 valid,
    output logic                 timeout,
    output logic                 busy
);

    localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(cnt_max(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    logic sig_sync;
    logic sig_rise;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk  (clk),
        .rst  (rst),
        .d    (sig_in),
        .q    (sig_sync),
        .rise (sig_rise)
    );

    meter_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] high_q, high_d;
    logic                 valid_q, valid_d;
    logic                 timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        if (!enable) begin
            state_d   = StIdle;
            cnt_d     = '0;
            hcnt_d    = '0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StArm;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                end
                StArm: begin
                    if (sig_rise) begin
                        // First edge only opens the window; the rise cycle is high.
                        state_d = StMeasure;
                        cnt_d   = CntOne;
                        hcnt_d  = CntOne;
                    end else if (cnt_q == CntMax) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        hcnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StMeasure: begin
                    // Rise takes priority over saturation in the same cycle.
                    if (sig_rise) begin
                        period_d  = cnt_q;
                        high_d    = hcnt_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = CntOne;
                        hcnt_d    = CntOne;
                    end else if (cnt_q == CntMax) begin
                        state_d   = StArm;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        hcnt_d    = '0;
                    end else begin
                        cnt_d  = cnt_q + CntOne;
                        hcnt_d = hcnt_q + CNT_WIDTH'(sig_sync);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter: waveform-level reference model feeds an
// expectation queue; a negedge monitor checks every valid pulse against it.
`timescale 1ns / 1ps
module tb_clock_period_meter;

    localparam int unsigned W    = 12;
    localparam int unsigned SYNC = 2;
    localparam int unsigned TMO  = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sig_in = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         timeout;
    logic         busy;

    clock_period_meter #(
        .CNT_WIDTH   (W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .enable    (enable),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned period;
        int unsigned high;
        int unsigned due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    function automatic void check(input string name, input longint unsigned act,
                                  input longint unsigned req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endfunction

    // Reference model: works on the driven waveform. A measurement is the distance
    // between consecutive sampled rises while enabled; high time is rise-to-fall.
    int unsigned cyc       = 0;
    int unsigned last_rise = 0;
    int unsigned last_fall = 0;
    bit          have_ref  = 1'b0;
    bit          prev_sig  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            have_ref = 1'b0;
            prev_sig = 1'b0;
        end else begin
            cyc++;
            if (!enable) begin
                have_ref = 1'b0;
            end else if (sig_in && !prev_sig) begin
                if (have_ref)
                    exp_q.push_back('{period: cyc - last_rise, high: last_fall - last_rise,
                                      due: cyc + SYNC});
                last_rise = cyc;
                have_ref  = 1'b1;
            end
            if (!sig_in && prev_sig) last_fall = cyc;
            prev_sig = sig_in;
        end
    end

    always @(negedge clk) begin
        if (!rst && valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_valid: valid=1 at cycle %0d, required 0", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("period", period, mon_e.period);
                check("high_time", high_time, mon_e.high);
                check("valid_cycle", cyc, mon_e.due);
                check("timeout_on_valid", timeout, 0);
            end
        end
    end

    initial begin
        #(50000 * 10);
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_period(input int unsigned hi, input int unsigned lo);
        sig_in = 1'b1;
        repeat (hi) step();
        sig_in = 1'b0;
        repeat (lo) step();
    endtask

    task automatic drive_div(input int unsigned div, input int unsigned n);
        for (int i = 0; i < n; i++) drive_period(div - div / 2, div / 2);
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_period", period, 0);
        check("rst_high_time", high_time, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // Timeout with sig_in held low
        enable = 1'b1;
        step();
        check("arm_busy", busy, 1);
        repeat (TMO - 1) step();
        check("timeout_before", timeout, 0);
        step();
        check("timeout_set", timeout, 1);
        check("timeout_busy", busy, 1);
        check("timeout_period", period, 0);

        // Divider inputs; the first valid clears timeout
        drive_div(10, 6);
        check("timeout_cleared", timeout, 0);
        drive_div(2, 10);
        for (int i = 0; i < 8; i++) drive_period(1, 3);

        // Randomised duty cycles
        for (int i = 0; i < 40; i++) drive_period($urandom_range(25, 1), $urandom_range(25, 1));

        // Single-cycle enable drop mid-period
        drive_div(16, 4);
        sig_in = 1'b1;
        repeat (8) step();
        sig_in = 1'b0;
        repeat (3) step();
        enable = 1'b0;
        step();
        check("disable_busy", busy, 0);
        check("disable_period", period, 16);
        enable = 1'b1;
        repeat (4) step();
        drive_div(16, 4);

        // Long period
        drive_div(1234, 3);
        check("long_timeout", timeout, 0);

        // Asynchronous reset mid-measurement
        drive_div(10, 3);
        repeat (5) step();
        check("pre_rst_drained", exp_q.size(), 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_period", period, 0);
        check("async_rst_high_time", high_time, 0);
        check("async_rst_valid", valid, 0);
        check("async_rst_timeout", timeout, 0);
        check("async_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        drive_div(10, 5);

        repeat (10) step();
        check("pending_expected", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/clock_period_meter.md
CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of the period counter, high-time counter and result outputs.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on sig_in (minimum 2).
REQ-003 SHALL have one clock and an asynchronous, active-high reset; port list in REQ-004..REQ-012.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sig_in  input  1  asynchronous signal under measurement, e.g. a clock_divider clk_out.
REQ-007 enable  input  1  level; 1 = measure, 0 = idle.
REQ-008 period  output  CNT_WIDTH  clk cycles between the last two sig_in rising edges.
REQ-009 high_time  output  CNT_WIDTH  clk cycles sig_in was high within that period.
REQ-010 valid  output  1  one-cycle pulse; period/high_time updated this cycle.
REQ-011 timeout  output  1  sticky level; no rising edge within 2^CNT_WIDTH-1 cycles.
REQ-012 busy  output  1  1 while in ARM or MEASURE.

Function
REQ-013 sig_in SHALL pass through SYNC_STAGES flops (reset 0) to give s; a rising edge (rise) SHALL be s=1 while the previous s=0.
REQ-014 FSM states SHALL be IDLE, ARM and MEASURE.
REQ-015 IDLE: cnt=0, hcnt=0, busy=0; enable=1 -> ARM with cnt<=0.
REQ-016 ARM: cnt increments each cycle; rise -> MEASURE with cnt<=1, hcnt<=1; no valid pulse.
REQ-017 MEASURE: cnt increments each cycle; hcnt<=hcnt+s.
REQ-018 MEASURE on rise: period<=cnt, high_time<=hcnt, valid<=1 for one cycle, timeout<=0, cnt<=1, hcnt<=1; state stays MEASURE.
REQ-019 Result: for a steady input of N cycles per period, period=N and high_time = number of high cycles; valid SHALL repeat every N cycles.
REQ-020 Latency: valid and the new results SHALL be registered on the clk edge that ends the cycle in which rise is detected (SYNC_STAGES+1 cycles after the sig_in edge).
REQ-021 If cnt == 2^CNT_WIDTH-1 in ARM or MEASURE without rise: timeout<=1, go to ARM with cnt<=0, and period/high_time SHALL hold.
REQ-022 If rise and cnt saturation occur in the same cycle, rise SHALL win (REQ-018).
REQ-023 hcnt SHALL never exceed cnt and SHALL never wrap.
REQ-024 enable=0 in any state: next state IDLE, counters cleared, timeout<=0, no valid; period/high_time hold.
REQ-025 The minimum measurable period SHALL be 2; a 1-cycle sig_in pulse SHALL count as one high cycle.

Reset
REQ-026 rst=1 SHALL immediately force IDLE and set period=0, high_time=0, valid=0, timeout=0, busy=0, and clear cnt, hcnt and all synchronizer and edge flops, independent of clk.
REQ-027 Reset removal SHALL be synchronized externally; the first measurement after reset requires two rising edges.

Structure
REQ-028 Package clock_meter_pkg SHALL hold the FSM state encoding (IDLE=0, ARM=1, MEASURE=2, 2 bits) and a CNT_MAX helper for 2^CNT_WIDTH-1.
REQ-029 Sub-module sync_edge_detect SHALL contain the SYNC_STAGES synchronizer and rise detector (ports clk, rst, d, q, rise); all other logic stays in clock_period_meter.

Verification (stimulus from clock_divider, clk period 1 us)
REQ-030 clock_divider DIVISOR=2, enable=1 -> valid every 2 cycles from the second edge onward, period=2, high_time=1.
REQ-031 DIVISOR=10 -> period=10, high_time=5; DIVISOR=1234 -> period=1234, high_time=617, timeout=0.
REQ-032 CNT_WIDTH=8, sig_in held 0, enable rises -> timeout=1 exactly 256 clk edges after enable is first sampled, busy stays 1, period=0; a DIVISOR=10 input applied afterwards -> first valid clears timeout.
REQ-033 DIVISOR=16 measuring; enable=0 for 1 cycle mid-period -> busy=0 next cycle, no valid, period stays 16; after re-enable, the first valid occurs on the second rise, with period=16.
REQ-034 rst pulsed asynchronously (between clk edges) mid-measurement -> all outputs 0 before the next clk edge; first valid after release is on the second rise.
REQ-035 sig_in pattern high 1 / low 3 cycles -> period=4, high_time=1.
